fp_normalizer: RTL and testbench
================================

# fp_normalizer

Sequential post-normalize and round unit for the single-precision floating-point adder. It sits downstream of the big mantissa ALU, at the opposite end of the exponent path from the small exponent ALU. It takes the raw sum/difference mantissa with its working exponent and sign, and normalizes it one bit per cycle. It then rounds to nearest-even and emits a packed IEEE-754 word with overflow/underflow flags.

## Interface
- No parameters. Format is fixed: 8-bit exponent, 23-bit fraction.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  request. Sampled only in IDLE and ignored while busy.
- sign_in  input  1  result sign. Passed through unchanged.
- exp_in  input  8  working (biased) exponent.
- mant_in  input  27  bit layout:
  - [26] carry-out
  - [25] hidden bit
  - [24:2] fraction
  - [1] guard G
  - [0] sticky S
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse. result and flags are valid while it is high and held until the next start.
- result  output  32  {sign, exp[7:0], mant[24:2]}.
- overflow  output  1  result forced to ±infinity.
- underflow  output  1  result flushed to ±zero.

## Operation
- State machine states: IDLE, CHECK, ROUND, DONE.
- IDLE:
  - On start, latch sign_in, exp_in and mant_in into the internal registers s, e and m.
  - Clear the flags, set busy, go to CHECK.
- CHECK performs one action per cycle, in this priority order:
  1. e == 255: result = {s, 8'hFF, 23'd0}, overflow = 1, go to DONE.
  2. m == 0: result = {s, 31'd0}, go to DONE. underflow stays 0.
  3. m[26] = 1: right shift, m ← {1'b0, m[26:2], m[1]|m[0]}, e ← e+1, go to ROUND.
     - If e+1 == 255, produce ±infinity with overflow = 1 and go to DONE instead.
  4. m[25] = 1: go to ROUND.
  5. Otherwise:
     - If e ≤ 1: produce ±zero with underflow = 1, go to DONE. Denormals are not produced.
     - Else left shift, m ← {m[25:0], 1'b0}, e ← e−1, stay in CHECK.
- ROUND:
  - With L = m[2], round up when G & (S | L): m[26:2] ← m[26:2] + 1.
  - Clear m[1:0].
  - If the increment sets m[26], return to CHECK, which renormalizes with one right shift and then rounds again (no further carry is possible).
  - Else result = {s, e[7:0], m[24:2]}, go to DONE.
- DONE: done = 1, busy = 0, go to IDLE.
- Arithmetic rules:
  - The exponent is held internally as 9 bits, so overflow and underflow are detected without wrap-around.
  - A left shift moves the sticky bit into the guard bit. This is accepted: left shifts only occur after cancellation, where S is 0.

## Timing
- Count edges from the edge E0 that samples start. done is high in the cycle after edge E0+N.
- Already-normalized input, or a single right shift, no round carry: N = 3, i.e. IDLE → CHECK → ROUND → DONE.
- Each left shift adds 1 cycle.
- A round carry adds 2 cycles (ROUND → CHECK → ROUND).
- Special cases (zero, overflow, underflow, exp_in = 255): N = 2.
- start asserted while busy or in DONE is ignored. A new start is accepted in the IDLE cycle right after DONE, giving back-to-back throughput of one op every N+1 edges.
- Reset values: state = IDLE, busy = 0, done = 0, result = 0, overflow = 0, underflow = 0.
- Reset asserted mid-operation aborts immediately: no done pulse and the outputs clear. The first start after reset deasserts is handled normally.

## Test plan
- exp_in = 127, mant_in = 27'h2000000, sign_in = 0 → result 32'h3F800000, flags 0, done 3 edges after start, busy high for exactly 2 cycles before it.
- exp_in = 127, mant_in = 27'h4000000, sign_in = 1 → result 32'hC0000000 (−2.0), latency 3.
- exp_in = 127, mant_in = 27'h0800000 → two left shifts, result 32'h3E800000 (0.25), latency 5.
- exp_in = 127, mant_in = 27'h3FFFFFE → round up carries into m[26], renormalizes, result 32'h40000000, latency 5.
- Overflow case: exp_in = 254, mant_in = 27'h4000000 → result 32'h7F800000, overflow = 1.
- Underflow case: exp_in = 1, mant_in = 27'h1000000 → result 32'h00000000, underflow = 1.
- Zero case: mant_in = 0 → result 0, both flags 0, latency 2.
- Busy and reset behaviour:
  - start pulsed while busy → ignored; the in-flight result is unchanged.
  - reset asserted during the left shifts → outputs 0 at once, no done pulse.

Source files
------------

// File: rtl/fp_normalizer.sv
// Post-normalize and round-to-nearest-even stage of the single-precision adder.
// Normalizes the raw ALU mantissa one bit per cycle, then packs an IEEE-754 word.
module fp_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [26:0] mant_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, CHECK, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic        s, s_nxt;
  logic [8:0]  e, e_nxt;
  logic [26:0] m, m_nxt;
  logic [31:0] result_nxt;
  logic        overflow_nxt, underflow_nxt, busy_nxt, done_nxt;
  logic [8:0]  e_inc;
  logic        round_up;
  logic [24:0] m_rnd;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s         <= 1'b0;
      e         <= 9'd0;
      m         <= 27'd0;
      result    <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      e         <= e_nxt;
      m         <= m_nxt;
      result    <= result_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Handshake: start is sampled only in IDLE; busy drops as DONE is entered,
  // and done is a registered one-cycle pulse on the edge leaving DONE.
  always_comb begin
    state_nxt     = state;
    s_nxt         = s;
    e_nxt         = e;
    m_nxt         = m;
    result_nxt    = result;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    e_inc         = e + 9'd1;
    round_up      = m[1] & (m[0] | m[2]);
    m_rnd         = m[26:2] + {24'd0, round_up};

    case (state)
      IDLE: begin
        if (start) begin
          s_nxt         = sign_in;
          e_nxt         = {1'b0, exp_in};
          m_nxt         = mant_in;
          overflow_nxt  = 1'b0;
          underflow_nxt = 1'b0;
          busy_nxt      = 1'b1;
          state_nxt     = CHECK;
        end
      end
      CHECK: begin
        if (e == 9'd255) begin
          result_nxt   = {s, 8'hFF, 23'd0};
          overflow_nxt = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = DONE;
        end else if (m == 27'd0) begin
          result_nxt = {s, 31'd0};
          busy_nxt   = 1'b0;
          state_nxt  = DONE;
        end else if (m[26]) begin
          if (e_inc == 9'd255) begin
            result_nxt   = {s, 8'hFF, 23'd0};
            overflow_nxt = 1'b1;
            busy_nxt     = 1'b0;
            state_nxt    = DONE;
          end else begin
            // Right shift folds the lost bits into sticky.
            m_nxt     = {1'b0, m[26:2], m[1] | m[0]};
            e_nxt     = e_inc;
            state_nxt = ROUND;
          end
        end else if (m[25]) begin
          state_nxt = ROUND;
        end else if (e <= 9'd1) begin
          result_nxt    = {s, 31'd0};
          underflow_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = DONE;
        end else begin
          m_nxt = {m[25:0], 1'b0};
          e_nxt = e - 9'd1;
        end
      end
      ROUND: begin
        m_nxt = {m_rnd, 2'b00};
        if (m_rnd[24]) begin
          state_nxt = CHECK;
        end else begin
          result_nxt = {s, e[7:0], m_rnd[22:0]};
          busy_nxt   = 1'b0;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer: hand-computed results, flags, latency,
// busy width, ignored start while busy, and mid-operation reset.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [26:0] mant_in;
  logic        busy, done, overflow, underflow;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  fp_normalizer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op, wait (bounded) for done, then check result, flags, latency
  // and busy width. poke re-asserts start mid-flight with different operands.
  task automatic run_op(input string name, input logic s, input logic [7:0] e,
                        input logic [26:0] m, input logic [31:0] exp_res,
                        input logic exp_ov, input logic exp_un, input int exp_lat,
                        input bit poke);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1; sign_in = s; exp_in = e; mant_in = m;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 60) begin
      if (poke && lat == 1) begin
        start = 1'b1; sign_in = ~s; exp_in = 8'd20; mant_in = 27'h2000000;
      end
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 2) start = 1'b0;
      if (!done && busy) bcnt++;
    end
    check({name, " result"}, result, exp_res);
    check({name, " overflow"}, {31'd0, overflow}, {31'd0, exp_ov});
    check({name, " underflow"}, {31'd0, underflow}, {31'd0, exp_un});
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy_cycles"}, bcnt, exp_lat - 1);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; sign_in = 1'b0; exp_in = 8'd0; mant_in = 27'd0;
    repeat (2) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset flags", {30'd0, overflow, underflow}, 32'd0);
    check("reset busy_done", {30'd0, busy, done}, 32'd0);
    check("reset state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    run_op("one",        1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 3, 1'b0);
    // done must be a single-cycle pulse with result held afterwards
    @(posedge clk); #1;
    check("done pulse width", {31'd0, done}, 32'd0);
    check("result held", result, 32'h3F800000);
    run_op("minus_two",  1'b1, 8'd127, 27'h4000000, 32'hC0000000, 1'b0, 1'b0, 3, 1'b0);
    run_op("quarter",    1'b0, 8'd127, 27'h0800000, 32'h3E800000, 1'b0, 1'b0, 5, 1'b0);
    run_op("round_carry",1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 5, 1'b0);
    run_op("tie_even_dn",1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 3, 1'b0);
    run_op("tie_odd_up", 1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 3, 1'b0);
    run_op("sticky_up",  1'b0, 8'd127, 27'h2000003, 32'h3F800001, 1'b0, 1'b0, 3, 1'b0);
    run_op("rshift_rnd", 1'b0, 8'd127, 27'h4000006, 32'h40000001, 1'b0, 1'b0, 3, 1'b0);
    run_op("zero",       1'b0, 8'd100, 27'h0000000, 32'h00000000, 1'b0, 1'b0, 2, 1'b0);
    run_op("exp255",     1'b1, 8'd255, 27'h2000000, 32'hFF800000, 1'b1, 1'b0, 2, 1'b0);
    run_op("underflow",  1'b0, 8'd1,   27'h1000000, 32'h00000000, 1'b0, 1'b1, 2, 1'b0);
    run_op("carry_ovf",  1'b0, 8'd254, 27'h3FFFFFE, 32'h7F800000, 1'b1, 1'b0, 4, 1'b0);
    run_op("overflow",   1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 2, 1'b0);
    run_op("busy_poke",  1'b0, 8'd127, 27'h0800000, 32'h3E800000, 1'b0, 1'b0, 5, 1'b1);
    run_op("overflow2",  1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 2, 1'b0);

    // Reset in the middle of the left shifts
    @(negedge clk);
    start = 1'b1; sign_in = 1'b0; exp_in = 8'd127; mant_in = 27'h0800000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort result", result, 32'd0);
    check("abort flags", {30'd0, overflow, underflow}, 32'd0);
    check("abort busy_done", {30'd0, busy, done}, 32'd0);
    check("abort state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort no done", done_seen, 0);
    run_op("after_reset", 1'b1, 8'd130, 27'h3000000, 32'hC1400000, 1'b0, 1'b0, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
